// File: rtl/mc_core_pkg.sv
// Shared encodings for the mc_core accumulator machine: opcodes, FSM states
// and the bit positions of the fields inside the opcode word.
package mc_core_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LD   = 4'h1,
    OP_ST   = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_CALL = 4'hA,
    OP_RET  = 4'hB,
    OP_IN   = 4'hC,
    OP_OUT  = 4'hD,
    OP_ADC  = 4'hE,
    OP_HLT  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_IO_WAIT = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  // Opcode field and operand-mode bit inside the instruction word
  localparam int OPC_MSB  = 3;
  localparam int OPC_LSB  = 0;
  localparam int MODE_BIT = 4;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the accumulator ops (LD, ADD, SUB, AND, OR, XOR, ADC).
// Produces the next accumulator value, the next carry and the zero flag.
module mc_alu
  import mc_core_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  opcode_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o,
  output logic             z_o,
  output logic             wr_acc_o
);

  logic [WIDTH:0] add_d;
  logic [WIDTH:0] adc_d;

  assign add_d = {1'b0, a_i} + {1'b0, b_i};
  assign adc_d = add_d + {{WIDTH{1'b0}}, c_i};

  // Select result and carry; ops that do not own the carry pass it through
  always_comb begin
    res_o    = a_i;
    c_o      = c_i;
    wr_acc_o = 1'b0;
    case (op_i)
      OP_LD: begin
        res_o    = b_i;
        wr_acc_o = 1'b1;
      end
      OP_ADD: begin
        res_o    = add_d[WIDTH-1:0];
        c_o      = add_d[WIDTH];
        wr_acc_o = 1'b1;
      end
      OP_SUB: begin
        res_o    = a_i - b_i;
        c_o      = (a_i < b_i);
        wr_acc_o = 1'b1;
      end
      OP_AND: begin
        res_o    = a_i & b_i;
        c_o      = 1'b0;
        wr_acc_o = 1'b1;
      end
      OP_OR: begin
        res_o    = a_i | b_i;
        c_o      = 1'b0;
        wr_acc_o = 1'b1;
      end
      OP_XOR: begin
        res_o    = a_i ^ b_i;
        c_o      = 1'b0;
        wr_acc_o = 1'b1;
      end
      OP_ADC: begin
        res_o    = adc_d[WIDTH-1:0];
        c_o      = adc_d[WIDTH];
        wr_acc_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign z_o = (res_o == '0);

endmodule

// File: rtl/mc_core.sv
// mc_core: multi-cycle accumulator CPU. FETCH latches an instruction on the
// memory ack, EXEC retires it, IO_WAIT holds an IN/OUT handshake and HALT
// freezes the machine until reset. Register file, PC, LR and flags live here.
module mc_core
  import mc_core_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int REG_SIZE     = 9,
  parameter int REG_SEL_SIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_instr,
  input  logic [WIDTH-1:0] imem_arg,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] acc,
  output logic             halted
);

  state_e           state_q;
  opcode_e          op_q;
  logic             mode_q;
  logic [WIDTH-1:0] arg_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] lr_q;
  logic             z_q;
  logic             c_q;
  logic [WIDTH-1:0] rf_q [REG_SIZE];
  logic             imem_req_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             halted_q;

  logic [REG_SEL_SIZE-1:0] idx_d;
  logic                    idx_ok_d;
  logic [WIDTH-1:0]        rf_rd_d;
  logic [WIDTH-1:0]        opb_d;
  logic [WIDTH-1:0]        pc_plus1_d;
  logic [WIDTH-1:0]        alu_res_d;
  logic                    alu_c_d;
  logic                    alu_z_d;
  logic                    alu_wr_d;
  logic                    unused_instr_bits;

  // Only the opcode and mode fields of the instruction word carry meaning
  assign unused_instr_bits = ^imem_instr[WIDTH-1:MODE_BIT+1];

  // Operand decode: indices past the register file read as zero
  assign idx_d      = arg_q[REG_SEL_SIZE-1:0];
  assign idx_ok_d   = (32'(idx_d) < REG_SIZE);
  assign rf_rd_d    = idx_ok_d ? rf_q[idx_d] : '0;
  assign opb_d      = mode_q ? rf_rd_d : arg_q;
  assign pc_plus1_d = pc_q + WIDTH'(1);

  mc_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op_i    (op_q),
    .a_i     (acc_q),
    .b_i     (opb_d),
    .c_i     (c_q),
    .res_o   (alu_res_d),
    .c_o     (alu_c_d),
    .z_o     (alu_z_d),
    .wr_acc_o(alu_wr_d)
  );

  // Control FSM plus all architectural state, with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      op_q        <= OP_NOP;
      mode_q      <= 1'b0;
      arg_q       <= '0;
      pc_q        <= '0;
      acc_q       <= '0;
      lr_q        <= '0;
      z_q         <= 1'b1;
      c_q         <= 1'b0;
      imem_req_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      for (int i = 0; i < REG_SIZE; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          // Request is off only on the first cycle out of reset
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (imem_ack) begin
            op_q       <= opcode_e'(imem_instr[OPC_MSB:OPC_LSB]);
            mode_q     <= imem_instr[MODE_BIT];
            arg_q      <= imem_arg;
            imem_req_q <= 1'b0;
            state_q    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
          pc_q       <= pc_plus1_d;
          if (alu_wr_d) begin
            acc_q <= alu_res_d;
            z_q   <= alu_z_d;
            c_q   <= alu_c_d;
          end
          case (op_q)
            OP_ST: begin
              if (idx_ok_d) rf_q[idx_d] <= acc_q;
            end
            OP_JMP: pc_q <= opb_d;
            OP_JZ: begin
              if (z_q) pc_q <= opb_d;
            end
            OP_CALL: begin
              lr_q <= pc_plus1_d;
              pc_q <= opb_d;
            end
            OP_RET: pc_q <= lr_q;
            // I/O holds the PC until the handshake completes
            OP_IN: begin
              state_q    <= ST_IO_WAIT;
              imem_req_q <= 1'b0;
              pc_q       <= pc_q;
              in_ready_q <= 1'b1;
            end
            OP_OUT: begin
              state_q     <= ST_IO_WAIT;
              imem_req_q  <= 1'b0;
              pc_q        <= pc_q;
              out_valid_q <= 1'b1;
            end
            OP_HLT: begin
              state_q    <= ST_HALT;
              imem_req_q <= 1'b0;
              pc_q       <= pc_q;
              halted_q   <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_IO_WAIT: begin
          if (in_ready_q && in_valid) begin
            acc_q      <= in_data;
            z_q        <= (in_data == '0);
            in_ready_q <= 1'b0;
            pc_q       <= pc_plus1_d;
            imem_req_q <= 1'b1;
            state_q    <= ST_FETCH;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            pc_q        <= pc_plus1_d;
            imem_req_q  <= 1'b1;
            state_q     <= ST_FETCH;
          end
        end
        ST_HALT: ;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_mc_core.sv
// Bench for mc_core: behavioural instruction memory and I/O responders,
// a table of ALU/flag vectors, directed control-flow and handshake sequences,
// and random straight-line programs checked against an ISA-level model.
module tb_mc_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_instr = '0;
  logic [7:0] imem_arg = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] pc;
  logic [7:0] acc;
  logic       halted;

  mc_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_instr(imem_instr),
    .imem_arg  (imem_arg),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pc        (pc),
    .acc       (acc),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] mem_i [256];
  logic [7:0] mem_a [256];
  logic [7:0] in_q [$];
  logic [7:0] out_got [$];
  int         trace [$];
  int         in_idx;
  int         ack_max = 0, in_max = 0, out_max = 0;
  int         in_fixed = 0, out_fixed = 0;
  int         ack_cnt, in_cnt, out_cnt;

  logic [7:0] exp_out [$];
  int         exp_acc, exp_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory and I/O responders: inputs driven on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      imem_ack  = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_idx    = 0;
      out_got.delete();
      trace.delete();
      ack_cnt = 0;
      in_cnt  = 0;
      out_cnt = 0;
    end else begin
      if (imem_req) begin
        if (ack_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_instr = mem_i[imem_addr];
          imem_arg   = mem_a[imem_addr];
          trace.push_back(int'(imem_addr));
        end else begin
          imem_ack = 1'b0;
          ack_cnt--;
        end
      end else begin
        imem_ack = 1'b0;
        ack_cnt  = $urandom_range(ack_max, 0);
      end
      if (in_ready) begin
        in_data = (in_idx < in_q.size()) ? in_q[in_idx] : 8'h00;
        if (in_cnt == 0) begin
          in_valid = 1'b1;
          in_idx++;
        end else begin
          in_valid = 1'b0;
          in_cnt--;
        end
      end else begin
        in_valid = 1'b0;
        in_cnt   = (in_fixed >= 0) ? in_fixed : $urandom_range(in_max, 0);
      end
      if (out_valid) begin
        if (out_cnt == 0) begin
          out_ready = 1'b1;
          out_got.push_back(out_data);
        end else begin
          out_ready = 1'b0;
          out_cnt--;
        end
      end else begin
        out_ready = 1'b0;
        out_cnt   = (out_fixed >= 0) ? out_fixed : $urandom_range(out_max, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem_i[i] = 8'h0F;
      mem_a[i] = 8'h00;
    end
  endtask

  task automatic put(input int addr, input int op, input int mode, input int arg);
    mem_i[addr] = 8'((op & 15) | ((mode & 1) << 4));
    mem_a[addr] = 8'(arg);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_halt(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halt"}, halted, 1'b1);
  endtask

  task automatic check_trace(input string name, input int e[$]);
    check({name, "_len"}, trace.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < trace.size()) check($sformatf("%s_addr%0d", name, i), trace[i], e[i]);
    end
  endtask

  // ISA-level reference: interpret the program in mem_i/mem_a directly
  task automatic model_run();
    int a = 0, c = 0, z = 1, p = 0, k = 0, steps = 0;
    int rf [16];
    int op, mode, arg, idx, b, s;
    for (int i = 0; i < 16; i++) rf[i] = 0;
    exp_out.delete();
    while (steps < 300) begin
      op   = int'(mem_i[p]) & 15;
      mode = (int'(mem_i[p]) >> 4) & 1;
      arg  = int'(mem_a[p]);
      idx  = arg & 15;
      b    = mode ? ((idx < 9) ? rf[idx] : 0) : arg;
      if (op == 15) break;
      case (op)
        1: a = b;
        2: if (idx < 9) rf[idx] = a;
        3: begin s = a + b; c = (s > 255); a = s & 255; end
        4: begin c = (a < b); a = (a - b) & 255; end
        5: begin a = a & b; c = 0; end
        6: begin a = a | b; c = 0; end
        7: begin a = a ^ b; c = 0; end
        14: begin s = a + b + c; c = (s > 255); a = s & 255; end
        12: begin a = int'(in_q[k]); k++; end
        13: exp_out.push_back(8'(a));
        default: ;
      endcase
      if (op == 1 || (op >= 3 && op <= 7) || op == 14 || op == 12) z = (a == 0);
      p = (p + 1) & 255;
      steps++;
    end
    exp_acc = a;
    exp_pc  = p;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eacc;
    logic       ec;
    logic       ez;
  } vec_t;

  vec_t vt [16];

  initial begin
    int e [$];
    int n;
    int ops [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 14, 12, 13};
    logic stable;

    // Carry is 1 entering every vector (prologue LD #FF, ADD #1)
    vt[0]  = '{4'h1, 8'h12, 8'h00, 8'h00, 1'b1, 1'b1};
    vt[1]  = '{4'h3, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
    vt[2]  = '{4'h3, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    vt[3]  = '{4'h3, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vt[4]  = '{4'h4, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vt[5]  = '{4'h4, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vt[6]  = '{4'h4, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1};
    vt[7]  = '{4'h5, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vt[8]  = '{4'h5, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1};
    vt[9]  = '{4'h6, 8'h50, 8'h0A, 8'h5A, 1'b0, 1'b0};
    vt[10] = '{4'h7, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1};
    vt[11] = '{4'h7, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0};
    vt[12] = '{4'hE, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0};
    vt[13] = '{4'hE, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1};
    vt[14] = '{4'hE, 8'h80, 8'h80, 8'h01, 1'b1, 1'b0};
    vt[15] = '{4'h0, 8'h33, 8'h00, 8'h33, 1'b1, 1'b0};

    // Reset values, first request and the LD/ADD/OUT latency
    clear_mem();
    put(0, 1, 0, 5); put(1, 3, 0, 3); put(2, 13, 0, 0);
    ack_max = 0; in_fixed = 0; out_fixed = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_pc", pc, 8'h00);
    check("rst_acc", acc, 8'h00);
    check("rst_halted", halted, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 8'h00);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("out_latency", n, 6);
    check("out_data_8", out_data, 8'h08);
    run_halt("t035", 50);
    check("t035_nout", out_got.size(), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_req", imem_req, 1'b0);
      check("halt_flag", halted, 1'b1);
      check("halt_pc", pc, 8'h03);
    end

    // ALU and flag vectors
    ack_max = 2; out_fixed = -1; out_max = 2;
    for (int v = 0; v < 16; v++) begin
      clear_mem();
      put(0, 1, 0, 'hFF); put(1, 3, 0, 1);
      put(2, 1, 0, int'(vt[v].a)); put(3, int'(vt[v].op), 0, int'(vt[v].b));
      put(4, 13, 0, 0); put(5, 9, 0, 'h10);
      put(6, 1, 0, 0); put(7, 14, 0, 0); put(8, 13, 0, 0);
      put(16, 1, 0, 'h80); put(17, 14, 0, 0); put(18, 13, 0, 0);
      do_reset();
      run_halt($sformatf("vec%0d", v), 300);
      check($sformatf("vec%0d_nout", v), out_got.size(), 2);
      if (out_got.size() == 2) begin
        check($sformatf("vec%0d_acc", v), out_got[0], vt[v].eacc);
        check($sformatf("vec%0d_flags", v), out_got[1], {vt[v].ez, 6'b0, vt[v].ec});
      end
    end

    // JZ taken and not taken
    ack_max = 0;
    clear_mem();
    put(0, 1, 0, 0); put(1, 9, 0, 'h10); put(16, 1, 0, 1); put(17, 9, 0, 'h20);
    do_reset();
    run_halt("jz", 100);
    e = '{0, 1, 16, 17, 18};
    check_trace("jz", e);

    // CALL/RET, including a nested CALL overwriting LR
    clear_mem();
    for (int i = 0; i < 4; i++) put(i, 0, 1, 0);
    put(4, 10, 0, 'h20); put('h20, 11, 0, 0);
    put(5, 10, 0, 'h30); put('h30, 10, 0, 'h40); put('h40, 11, 0, 0);
    do_reset();
    run_halt("call", 100);
    e = '{0, 1, 2, 3, 4, 'h20, 5, 'h30, 'h40, 'h31};
    check_trace("call", e);

    // Register-mode jump target
    clear_mem();
    put(0, 1, 0, 'h50); put(1, 2, 0, 2); put(2, 8, 1, 2);
    do_reset();
    run_halt("regjmp", 100);
    e = '{0, 1, 2, 'h50};
    check_trace("regjmp", e);

    // OUT held off by out_ready for five cycles
    clear_mem();
    put(0, 1, 0, 'h77); put(1, 13, 0, 0);
    out_fixed = 5;
    do_reset();
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("stall_seen", out_valid, 1'b1);
    n = 0;
    stable = 1'b1;
    while (out_valid && n < 20) begin
      if (out_data !== 8'h77 || pc !== 8'h01) stable = 1'b0;
      n++;
      @(negedge clk);
    end
    check("stall_cycles", n, 6);
    check("stall_stable", stable, 1'b1);
    run_halt("stall", 50);
    check("stall_pc", pc, 8'h02);

    // Asynchronous reset while waiting on IN
    clear_mem();
    put(0, 1, 0, 'h42); put(1, 12, 0, 0);
    in_fixed = 1000; out_fixed = 0;
    do_reset();
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("in_wait_ready", in_ready, 1'b1);
    check("in_wait_acc", acc, 8'h42);
    check("in_wait_pc", pc, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc", acc, 8'h00);
    check("arst_pc", pc, 8'h00);
    check("arst_in_ready", in_ready, 1'b0);
    check("arst_req", imem_req, 1'b0);

    // Random straight-line programs against the ISA model
    ack_max = 3; in_max = 3; out_max = 3; in_fixed = -1; out_fixed = -1;
    for (int t = 0; t < 20; t++) begin
      int len;
      clear_mem();
      len = $urandom_range(25, 5);
      for (int i = 0; i < len; i++)
        put(i, ops[$urandom_range(10, 0)], $urandom_range(1, 0), $urandom_range(255, 0));
      do_reset();
      for (int i = 0; i < 40; i++) in_q.push_back(8'($urandom_range(255, 0)));
      model_run();
      run_halt($sformatf("rnd%0d", t), 2000);
      check($sformatf("rnd%0d_nout", t), out_got.size(), exp_out.size());
      for (int i = 0; i < exp_out.size(); i++) begin
        if (i < out_got.size()) check($sformatf("rnd%0d_out%0d", t, i), out_got[i], exp_out[i]);
      end
      check($sformatf("rnd%0d_acc", t), acc, exp_acc);
      check($sformatf("rnd%0d_pc", t), pc, exp_pc);
      in_q.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
